// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// ID/EX pipeline register with EX-stage forwarding muxes. It sits directly
// upstream of the ALU. Each clock it captures the decoded operands and control
// from the decode stage. It resolves RAW hazards against the EX/MEM and MEM/WB
// stages and drives the ALU operation, the A/B operands and the shift amount.
// Write-back control is passed downstream.
//
// Optional feature macro: LOAD_USE_DETECT_EN
//   defined   : LoadUseStall flags a load in this stage whose destination is
//               read by the instruction now in decode (ID_Rs / ID_Rt).
//   undefined : LoadUseStall is tied to 0 and ID_Rs / ID_Rt are ignored.
//   The port list is the same in both builds.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   Stall, Flush        : hold stage / replace stage with bubble (Flush wins)
//   ReadData1/2         : register file rs / rt values from decode
//   Immediate, ShamtIn  : extended immediate and shamt field from decode
//   Rs, Rt, Rd          : register specifiers from decode
//   ALUSrc, RegDst      : B-from-immediate select, rd-vs-rt destination select
//   RegWriteIn,
//   MemReadIn, ALUOpIn  : control from decode
//   EXMEM_*, MEMWB_*    : forwarding sources from the two downstream stages
//   ID_Rs, ID_Rt        : source registers of the instruction now in decode
//   ALUOperation, A, B,
//   Shamt               : ALU inputs
//   StoreData           : forwarded rt value for stores
//   WriteReg, RegWrite,
//   MemRead, Valid      : registered control passed downstream
//   LoadUseStall        : load-use hazard request to decode
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic [DATA_WIDTH-1:0]     ReadData1,
  input  logic [DATA_WIDTH-1:0]     ReadData2,
  input  logic [DATA_WIDTH-1:0]     Immediate,
  input  logic [4:0]                ShamtIn,
  input  logic [REG_ADDR_WIDTH-1:0] Rs,
  input  logic [REG_ADDR_WIDTH-1:0] Rt,
  input  logic [REG_ADDR_WIDTH-1:0] Rd,
  input  logic                      ALUSrc,
  input  logic                      RegDst,
  input  logic                      RegWriteIn,
  input  logic                      MemReadIn,
  input  logic [3:0]                ALUOpIn,
  input  logic                      EXMEM_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] EXMEM_WriteReg,
  input  logic [DATA_WIDTH-1:0]     EXMEM_ALUResult,
  input  logic                      MEMWB_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] MEMWB_WriteReg,
  input  logic [DATA_WIDTH-1:0]     MEMWB_WriteData,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rt,
  output logic [3:0]                ALUOperation,
  output logic [DATA_WIDTH-1:0]     A,
  output logic [DATA_WIDTH-1:0]     B,
  output logic [4:0]                Shamt,
  output logic [DATA_WIDTH-1:0]     StoreData,
  output logic [REG_ADDR_WIDTH-1:0] WriteReg,
  output logic                      RegWrite,
  output logic                      MemRead,
  output logic                      Valid,
  output logic                      LoadUseStall
);

  // All stage state in one record, so that reset and Flush can load the
  // all-zero bubble with a single assignment.
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0]     read_data1;
    logic [DATA_WIDTH-1:0]     read_data2;
    logic [DATA_WIDTH-1:0]     immediate;
    logic [4:0]                shamt;
    logic                      alu_src;
    logic                      reg_write;
    logic                      mem_read;
    logic [3:0]                alu_op;
  } stage_t;

  stage_t stage_q, stage_d;

  // Next-state selection: Flush > Stall > load. Reset has top priority and is
  // applied in the register process.
  always_comb begin
    // NOTE: default to "hold" first so every path assigns stage_d; without the
    // default a path that skips the assignment would infer a latch.
    stage_d = stage_q;
    if (Flush) begin
      stage_d = '0;
    end else if (!Stall) begin
      stage_d.valid      = 1'b1;
      stage_d.rs         = Rs;
      stage_d.rt         = Rt;
      stage_d.write_reg  = RegDst ? Rd : Rt;
      stage_d.read_data1 = ReadData1;
      stage_d.read_data2 = ReadData2;
      stage_d.immediate  = Immediate;
      stage_d.shamt      = ShamtIn;
      stage_d.alu_src    = ALUSrc;
      stage_d.reg_write  = RegWriteIn;
      stage_d.mem_read   = MemReadIn;
      stage_d.alu_op     = ALUOpIn;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples its pre-edge value regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Forwarding select for one source register. EX/MEM holds the younger
  // result, so it is checked first. Register 0 is hard-wired and never
  // forwarded.
  function automatic logic [DATA_WIDTH-1:0] forward(
    input logic [REG_ADDR_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0]     reg_val,
    input logic                      exmem_we,
    input logic [REG_ADDR_WIDTH-1:0] exmem_reg,
    input logic [DATA_WIDTH-1:0]     exmem_val,
    input logic                      memwb_we,
    input logic [REG_ADDR_WIDTH-1:0] memwb_reg,
    input logic [DATA_WIDTH-1:0]     memwb_val
  );
    logic [DATA_WIDTH-1:0] result;
    result = reg_val;
    if (exmem_we && (exmem_reg != '0) && (exmem_reg == src)) begin
      result = exmem_val;
    end else if (memwb_we && (memwb_reg != '0) && (memwb_reg == src)) begin
      result = memwb_val;
    end
    return result;
  endfunction

  logic [DATA_WIDTH-1:0] fwd_rs, fwd_rt;

  always_comb begin
    fwd_rs = forward(stage_q.rs, stage_q.read_data1,
                     EXMEM_RegWrite, EXMEM_WriteReg, EXMEM_ALUResult,
                     MEMWB_RegWrite, MEMWB_WriteReg, MEMWB_WriteData);
    fwd_rt = forward(stage_q.rt, stage_q.read_data2,
                     EXMEM_RegWrite, EXMEM_WriteReg, EXMEM_ALUResult,
                     MEMWB_RegWrite, MEMWB_WriteReg, MEMWB_WriteData);
  end

  assign A            = fwd_rs;
  assign StoreData    = fwd_rt;
  assign B            = stage_q.alu_src ? stage_q.immediate : fwd_rt;
  assign ALUOperation = stage_q.alu_op;
  assign Shamt        = stage_q.shamt;
  assign WriteReg     = stage_q.write_reg;
  assign RegWrite     = stage_q.reg_write;
  assign MemRead      = stage_q.mem_read;
  assign Valid        = stage_q.valid;

`ifdef LOAD_USE_DETECT_EN
  // A load here cannot forward its data in time for the instruction in
  // decode, so decode must hold for one cycle while this stage takes a bubble.
  assign LoadUseStall = stage_q.mem_read && stage_q.reg_write &&
                        (stage_q.write_reg != '0) &&
                        ((stage_q.write_reg == ID_Rs) ||
                         (stage_q.write_reg == ID_Rt));
`else
  assign LoadUseStall = 1'b0;
  // The decode-stage specifiers have no function in this build.
  logic unused_id_regs;
  assign unused_id_regs = ^{ID_Rs, ID_Rt};
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Self-checking bench for alu_operand_stage. A behavioural model keeps a record
// of the instruction held in the stage and derives every output from it.
// Directed steps cover reset, load, forwarding priority, register 0, stall,
// flush and load-use. They are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush;
  logic [31:0] ReadData1, ReadData2, Immediate;
  logic [4:0]  ShamtIn, Rs, Rt, Rd;
  logic        ALUSrc, RegDst, RegWriteIn, MemReadIn;
  logic [3:0]  ALUOpIn;
  logic        EXMEM_RegWrite, MEMWB_RegWrite;
  logic [4:0]  EXMEM_WriteReg, MEMWB_WriteReg, ID_Rs, ID_Rt;
  logic [31:0] EXMEM_ALUResult, MEMWB_WriteData;

  logic [3:0]  ALUOperation;
  logic [31:0] A, B, StoreData;
  logic [4:0]  Shamt, WriteReg;
  logic        RegWrite, MemRead, Valid, LoadUseStall;

  int checks   = 0;
  int failures = 0;

  alu_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Immediate(Immediate),
    .ShamtIn(ShamtIn), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .ALUSrc(ALUSrc), .RegDst(RegDst), .RegWriteIn(RegWriteIn),
    .MemReadIn(MemReadIn), .ALUOpIn(ALUOpIn),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_WriteReg(EXMEM_WriteReg),
    .EXMEM_ALUResult(EXMEM_ALUResult),
    .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_WriteReg(MEMWB_WriteReg),
    .MEMWB_WriteData(MEMWB_WriteData),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ALUOperation(ALUOperation), .A(A), .B(B), .Shamt(Shamt),
    .StoreData(StoreData), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .Valid(Valid), .LoadUseStall(LoadUseStall)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The instruction the stage should hold, as the decode stage described it.
  typedef struct {
    bit       valid;
    bit [4:0] rs, rt, dest;
    bit [31:0] rd1, rd2, imm;
    bit [4:0] shamt;
    bit       alu_src, reg_write, mem_read;
    bit [3:0] op;
  } instr_t;

  instr_t held;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.rs = 0; b.rt = 0; b.dest = 0; b.rd1 = 0; b.rd2 = 0;
    b.imm = 0; b.shamt = 0; b.alu_src = 0; b.reg_write = 0; b.mem_read = 0;
    b.op = 0;
    return b;
  endfunction

  // The newest producer of a register supplies its value. Register 0 always
  // reads the value from the register file.
  function automatic bit [31:0] operand(bit [4:0] r, bit [31:0] file_val);
    if (r == 0) return file_val;
    if (EXMEM_RegWrite && EXMEM_WriteReg == r) return EXMEM_ALUResult;
    if (MEMWB_RegWrite && MEMWB_WriteReg == r) return MEMWB_WriteData;
    return file_val;
  endfunction

  function automatic bit exp_load_use();
`ifdef LOAD_USE_DETECT_EN
    return held.mem_read && held.reg_write && held.dest != 0 &&
           (held.dest == ID_Rs || held.dest == ID_Rt);
`else
    return 1'b0;
`endif
  endfunction

  // One rising edge: the model applies the same edge to its record, and
  // control returns on the falling edge for checking and new stimulus.
  task automatic tick();
    @(posedge clk);
    if (reset || Flush) begin
      held = bubble();
    end else if (!Stall) begin
      held.valid     = 1;
      held.rs        = Rs;
      held.rt        = Rt;
      held.dest      = RegDst ? Rd : Rt;
      held.rd1       = ReadData1;
      held.rd2       = ReadData2;
      held.imm       = Immediate;
      held.shamt     = ShamtIn;
      held.alu_src   = ALUSrc;
      held.reg_write = RegWriteIn;
      held.mem_read  = MemReadIn;
      held.op        = ALUOpIn;
    end
    @(negedge clk);
  endtask

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_all(string tag);
    bit [31:0] rt_val;
    rt_val = operand(held.rt, held.rd2);
    check({tag, ".A"},         A,            operand(held.rs, held.rd1));
    check({tag, ".StoreData"}, StoreData,    rt_val);
    check({tag, ".B"},         B,            held.alu_src ? held.imm : rt_val);
    check({tag, ".ALUOp"},     32'(ALUOperation), 32'(held.op));
    check({tag, ".Shamt"},     32'(Shamt),   32'(held.shamt));
    check({tag, ".WriteReg"},  32'(WriteReg), 32'(held.dest));
    check({tag, ".RegWrite"},  32'(RegWrite), 32'(held.reg_write));
    check({tag, ".MemRead"},   32'(MemRead), 32'(held.mem_read));
    check({tag, ".Valid"},     32'(Valid),   32'(held.valid));
    check({tag, ".LoadUse"},   32'(LoadUseStall), 32'(exp_load_use()));
  endtask

  task automatic rand_decode();
    ReadData1 = $urandom; ReadData2 = $urandom; Immediate = $urandom;
    ShamtIn = 5'($urandom_range(0, 31));
    Rs = 5'($urandom_range(0, 4)); Rt = 5'($urandom_range(0, 4));
    Rd = 5'($urandom_range(0, 4));
    ALUSrc = 1'($urandom); RegDst = 1'($urandom);
    RegWriteIn = 1'($urandom); MemReadIn = 1'($urandom);
    ALUOpIn = 4'($urandom_range(0, 15));
  endtask

  task automatic rand_forward();
    EXMEM_RegWrite = 1'($urandom); MEMWB_RegWrite = 1'($urandom);
    EXMEM_WriteReg = 5'($urandom_range(0, 4));
    MEMWB_WriteReg = 5'($urandom_range(0, 4));
    EXMEM_ALUResult = $urandom; MEMWB_WriteData = $urandom;
    ID_Rs = 5'($urandom_range(0, 4)); ID_Rt = 5'($urandom_range(0, 4));
  endtask

  task automatic quiet_forward();
    EXMEM_RegWrite = 0; MEMWB_RegWrite = 0;
    EXMEM_WriteReg = 0; MEMWB_WriteReg = 0;
    EXMEM_ALUResult = 0; MEMWB_WriteData = 0;
    ID_Rs = 0; ID_Rt = 0;
  endtask

  logic [31:0] a_hold, b_hold;

  initial begin
    held = bubble();
    reset = 1; Stall = 0; Flush = 0;
    rand_decode();
    rand_forward();

    // Reset for two cycles with arbitrary inputs.
    @(negedge clk);
    tick(); rand_decode(); rand_forward();
    tick();
    #1;
    check("rst_valid",    32'(Valid), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_aluop",    32'(ALUOperation), 32'd0);
    check("rst_writereg", 32'(WriteReg), 32'd0);
    check_all("rst");

    // Plain load: immediate on B, rd destination.
    reset = 0; quiet_forward();
    rand_decode();
    ReadData1 = 32'h0000_0005; Immediate = 32'h0000_FFFF; ALUSrc = 1;
    ALUOpIn = 4'b0011; RegDst = 1; Rd = 5'd9; Rs = 5'd3; MemReadIn = 0;
    tick(); #1;
    check("ld_A",     A, 32'h5);
    check("ld_B",     B, 32'h0000_FFFF);
    check("ld_aluop", 32'(ALUOperation), 32'h3);
    check("ld_wreg",  32'(WriteReg), 32'd9);
    check("ld_valid", 32'(Valid), 32'd1);
    check_all("ld");

    // Forwarding priority on rs = 8.
    Rs = 5'd8; ALUSrc = 0;
    tick();
    EXMEM_RegWrite = 1; EXMEM_WriteReg = 5'd8; EXMEM_ALUResult = 32'hAAAA_0000;
    MEMWB_RegWrite = 1; MEMWB_WriteReg = 5'd8; MEMWB_WriteData = 32'h1234_5678;
    #1;
    check("fwd_exmem", A, 32'hAAAA_0000);
    check_all("fwd_both");
    EXMEM_RegWrite = 0; #1;
    check("fwd_memwb", A, 32'h1234_5678);
    check_all("fwd_memwb");

    // Register 0 is never forwarded.
    quiet_forward();
    Rt = 5'd0; ReadData2 = 32'h0000_1111; ALUSrc = 0;
    tick();
    EXMEM_RegWrite = 1; EXMEM_WriteReg = 5'd0; EXMEM_ALUResult = 32'hDEAD_BEEF;
    MEMWB_RegWrite = 1; MEMWB_WriteReg = 5'd0; MEMWB_WriteData = 32'hCAFE_F00D;
    #1;
    check("r0_store", StoreData, 32'h0000_1111);
    check("r0_B",     B,         32'h0000_1111);

    // Stall for three cycles with changing decode inputs: stage holds.
    a_hold = A; b_hold = B;
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_decode();
      tick(); #1;
      check("stall_A", A, a_hold);
      check("stall_B", B, b_hold);
      check_all("stall");
    end

    // Stall and Flush together: Flush wins.
    Flush = 1;
    tick(); #1;
    check("flush_valid", 32'(Valid), 32'd0);
    check("flush_aluop", 32'(ALUOperation), 32'd0);
    check_all("flush");
    Stall = 0; Flush = 0;

    // Load to $4 in the stage, then probe the decode specifiers.
    quiet_forward();
    rand_decode();
    MemReadIn = 1; RegWriteIn = 1; RegDst = 0; Rt = 5'd4;
    tick();
    ID_Rs = 5'd1; ID_Rt = 5'd4; #1;
`ifdef LOAD_USE_DETECT_EN
    check("lu_hit", 32'(LoadUseStall), 32'd1);
`else
    check("lu_off", 32'(LoadUseStall), 32'd0);
`endif
    ID_Rs = 5'd5; ID_Rt = 5'd5; #1;
    check("lu_miss", 32'(LoadUseStall), 32'd0);
    check_all("lu");

    // Randomized run.
    for (int i = 0; i < 300; i++) begin
      rand_decode();
      rand_forward();
      reset = ($urandom_range(0, 19) == 0);
      Stall = ($urandom_range(0, 4) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      #1;
      check_all("rnd_pre");
      tick();
      rand_forward();
      #1;
      check_all("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
